// File: rtl/peripheral_display_scan.sv
// Multiplexed 7-segment scan controller feeding peripheral_deco7seg.
// Double-buffered display word, inter-digit blanking, leading-zero blanking.
module peripheral_display_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [4:0]  special_in,
    input  logic        extended_in,
    input  logic        blank_zeros,
    output logic [3:0]  D,
    output logic [4:0]  casesspecial,
    output logic        EXTENDED,
    output logic [1:0]  deco,
    output logic [3:0]  AN,
    output logic        frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [1:0]    IDX_LAST  = 2'(NUM_DIGITS - 1);

    logic [CW-1:0] slot_cnt;
    logic [1:0]    idx;
    logic          slot_wrap;
    logic          frame_wrap;

    logic [15:0]   pend_data;
    logic [4:0]    pend_special;
    logic          pend_ext;
    logic          pend_valid;

    logic [15:0]   act_data;
    logic [4:0]    act_special;
    logic          act_ext;

    logic          tail_zero;
    logic          suppress;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (idx == IDX_LAST);

    // Free-running slot timer and digit index; never stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Pending buffer: last load wins; a load on the boundary stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_data    <= '0;
            pend_special <= '0;
            pend_ext     <= 1'b0;
            pend_valid   <= 1'b0;
        end else if (load) begin
            pend_data    <= data_in;
            pend_special <= special_in;
            pend_ext     <= extended_in;
            pend_valid   <= 1'b1;
        end else if (frame_wrap) begin
            pend_valid   <= 1'b0;
        end
    end

    // Active buffer only changes at a frame boundary, so a frame never tears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_data    <= '0;
            act_special <= '0;
            act_ext     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (frame_wrap && pend_valid) begin
                act_data    <= pend_data;
                act_special <= pend_special;
                act_ext     <= pend_ext;
            end
        end
    end

    // Digit is blanked when it and every higher digit hold zero.
    always_comb begin
        tail_zero = 1'b1;
        suppress  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            tail_zero = tail_zero & (act_data[4*i +: 4] == 4'd0);
            if (2'(i) == idx) suppress = tail_zero;
        end
        suppress = suppress & blank_zeros & (act_special == 5'd0)
                 & ~act_ext & (idx != 2'd0);
    end

    // Anode drive: dark during the blanking window and for suppressed digits.
    always_comb begin
        AN = 4'b1111;
        if (slot_cnt >= BLANK_END && !suppress) AN[idx] = 1'b0;
    end

    assign deco         = idx;
    assign D            = act_data[{idx, 2'b00} +: 4];
    assign casesspecial = act_special;
    assign EXTENDED     = act_ext;

endmodule

// File: tb/tb_peripheral_display_scan.sv
// Scoreboard bench for peripheral_display_scan (PRESCALE=8, BLANK=2, 4 digits).
// Driver pushes expected outputs per cycle; monitor pops and compares.
module tb_peripheral_display_scan;

    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * PS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [4:0]  special_in = '0;
    logic        extended_in = 1'b0;
    logic        blank_zeros = 1'b0;
    logic [3:0]  D;
    logic [4:0]  casesspecial;
    logic        EXTENDED;
    logic [1:0]  deco;
    logic [3:0]  AN;
    logic        frame_done;

    peripheral_display_scan #(
        .NUM_DIGITS(ND),
        .PRESCALE(PS),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .load(load),
        .data_in(data_in),
        .special_in(special_in),
        .extended_in(extended_in),
        .blank_zeros(blank_zeros),
        .D(D),
        .casesspecial(casesspecial),
        .EXTENDED(EXTENDED),
        .deco(deco),
        .AN(AN),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [4:0] cs;
        logic       ext;
        logic [1:0] deco;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: cycle count since release plus the two buffers.
    int          k = 0;
    logic [15:0] m_pend_d = '0;
    logic [4:0]  m_pend_s = '0;
    logic        m_pend_e = 1'b0;
    logic        m_pv = 1'b0;
    logic [15:0] m_act_d = '0;
    logic [4:0]  m_act_s = '0;
    logic        m_act_e = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_pend_d = '0; m_pend_s = '0; m_pend_e = 1'b0; m_pv = 1'b0;
        m_act_d = '0;  m_act_s = '0;  m_act_e = 1'b0;
    endtask

    // Called at a negedge: drive inputs, advance model over next edge, push.
    task automatic step(input bit ld, input logic [15:0] d,
                        input logic [4:0] sp, input bit ex, input bit bz);
        exp_t e;
        int slot, dig;
        bit sup;
        load = ld; data_in = d; special_in = sp;
        extended_in = ex; blank_zeros = bz;
        if ((k % FRAME) == FRAME - 1 && m_pv) begin
            m_act_d = m_pend_d; m_act_s = m_pend_s; m_act_e = m_pend_e;
            m_pv = 1'b0;
        end
        if (ld) begin
            m_pend_d = d; m_pend_s = sp; m_pend_e = ex; m_pv = 1'b1;
        end
        k++;
        slot = k % PS;
        dig  = (k / PS) % ND;
        sup  = bz && m_act_s == 0 && !m_act_e && dig > 0
               && ((m_act_d >> (4 * dig)) == 16'd0);
        e.d    = 4'((m_act_d >> (4 * dig)) & 16'hF);
        e.cs   = m_act_s;
        e.ext  = m_act_e;
        e.deco = 2'(dig);
        e.an   = (slot >= BC && !sup) ? ~(4'b0001 << dig) : 4'b1111;
        e.fd   = ((k % FRAME) == 0);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit bz);
        for (int i = 0; i < n; i++) step(0, 16'h0, 5'h0, 0, bz);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_AN"}, AN, 4'b1111);
        chk({tag, "_D"}, D, 4'h0);
        chk({tag, "_deco"}, deco, 2'd0);
        chk({tag, "_fd"}, frame_done, 1'b0);
        chk({tag, "_cs"}, casesspecial, 5'd0);
        chk({tag, "_ext"}, EXTENDED, 1'b0);
    endtask

    // Monitor: the DUT presents a new output set after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("D", D, e.d);
                chk("casesspecial", casesspecial, e.cs);
                chk("EXTENDED", EXTENDED, e.ext);
                chk("deco", deco, e.deco);
                chk("AN", AN, e.an);
                chk("frame_done", frame_done, e.fd);
            end
        end
    end

    // Driver
    initial begin
        logic [15:0] rd;
        logic [4:0]  rs;
        bit          bzr;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        model_reset();

        // Scan order with 0x1234 loaded in the first frame.
        step(1, 16'h1234, 5'h0, 0, 0);
        idle(2 * FRAME, 0);

        // Double buffer: load 0xABCD mid-frame while digit 2 is shown.
        while (((k / PS) % ND) != 2) idle(1, 0);
        step(1, 16'hABCD, 5'h0, 0, 0);
        step(1, 16'h9876, 5'h0, 0, 0);
        step(1, 16'hABCD, 5'h0, 0, 0);
        idle(2 * FRAME, 0);

        // Leading-zero suppression.
        step(1, 16'h0050, 5'h0, 0, 1);
        idle(2 * FRAME, 1);
        step(1, 16'h0000, 5'h0, 0, 1);
        idle(2 * FRAME, 1);

        // Special and extended modes disable suppression.
        step(1, 16'h0000, 5'b00100, 0, 1);
        idle(2 * FRAME, 1);
        step(1, 16'h0000, 5'b00000, 1, 1);
        idle(2 * FRAME, 1);

        // Load exactly on the boundary edge, then another on the next one.
        while ((k % FRAME) != FRAME - 1) idle(1, 0);
        step(1, 16'h4321, 5'h0, 0, 0);
        while ((k % FRAME) != FRAME - 1) idle(1, 0);
        step(1, 16'h0F0F, 5'h3, 0, 0);
        idle(2 * FRAME, 0);

        // Randomised loads, modes and live blank_zeros.
        for (int n = 0; n < 800; n++) begin
            rd = 16'($urandom);
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 1) == 1) rd[4*j +: 4] = 4'h0;
            rs  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
            bzr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0)
                step(1, rd, rs, ($urandom_range(0, 4) == 0), bzr);
            else
                step(0, rd, rs, 0, bzr);
        end

        // Mid-scan reset at deco=2, slot=5 with a load still pending.
        while ((k % FRAME) != 9) idle(1, 0);
        step(1, 16'h7777, 5'h1, 1, 0);
        while ((k % FRAME) != 2 * PS + 5) idle(1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_AN", AN, 4'b1111);
        chk("midrst_deco", deco, 2'd0);
        @(negedge clk);
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        model_reset();
        idle(2 * FRAME + 3, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
